// File: rtl/baud_clock_pkg.sv
// Shared constants, types and helpers for the baud clock bank.
package baud_clock_pkg;

  // Smallest usable divisor; smaller values are clamped on use.
  localparam int unsigned MIN_DIV = 2;

  // Per-channel run state.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Divisor loaded at reset: one output period per baud interval.
  function automatic int unsigned calc_default_div(input int unsigned clk_hz,
                                                   input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Channel-select width; at least one bit even for a single channel.
  function automatic int cw_of(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  // Effective divisor: 0 and 1 behave as MIN_DIV.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  // High time is the rounded-up half, so odd periods are high one cycle longer.
  function automatic logic [31:0] high_time(input logic [31:0] deff);
    return deff - (deff >> 1);
  endfunction

endpackage

// File: rtl/baud_clock_bank_if.sv
// Control/status bundle of the baud clock bank.
interface baud_clock_bank_if
  import baud_clock_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DIV_WIDTH = 16
);
  localparam int CW = cw_of(CHANNELS);

  logic [CHANNELS-1:0]  enableIN;
  logic                 syncIN;
  logic                 cfgWrIN;
  logic [CW-1:0]        cfgChanIN;
  logic [DIV_WIDTH-1:0] cfgDivIN;
  logic [CHANNELS-1:0]  pendingOUT;
  logic [CHANNELS-1:0]  clockOUT;
  logic [CHANNELS-1:0]  tickOUT;

  modport master (
    output enableIN, syncIN, cfgWrIN, cfgChanIN, cfgDivIN,
    input  pendingOUT, clockOUT, tickOUT
  );

  modport slave (
    input  enableIN, syncIN, cfgWrIN, cfgChanIN, cfgDivIN,
    output pendingOUT, clockOUT, tickOUT
  );
endinterface

// File: rtl/baud_clock_channel.sv
// One divider channel: phase counter, active/pending divisor, registered outputs.
module baud_clock_channel
  import baud_clock_pkg::*;
#(
  parameter int                   DIV_WIDTH = 16,
  parameter logic [DIV_WIDTH-1:0] RESET_DIV = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 sync_i,
  input  logic                 wr_i,
  input  logic [DIV_WIDTH-1:0] wr_div_i,
  output logic                 pending_o,
  output logic                 clock_o,
  output logic                 tick_o
);

  ch_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] p_q, p_d;
  logic [DIV_WIDTH-1:0] a_q, a_d;
  logic [DIV_WIDTH-1:0] pdiv_q, pdiv_d;
  logic                 flag_q, flag_d;
  logic                 clock_q, clock_d;
  logic                 tick_q, tick_d;

  logic [31:0] deff;
  logic [31:0] high;
  logic        wrap;

  assign deff = clamp_div(32'(a_q));
  assign high = high_time(deff);
  assign wrap = (32'(p_q) == deff - 32'd1);

  // Next-state: disable idles at once, any boundary restarts the period and
  // consumes the pending divisor, and a same-edge write re-arms pending.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    pdiv_d  = pdiv_q;
    flag_d  = flag_q;
    clock_d = 1'b0;
    tick_d  = 1'b0;
    if (!enable_i) begin
      state_d = CH_IDLE;
      p_d     = '0;
      if (flag_q) begin
        a_d    = pdiv_q;
        flag_d = 1'b0;
      end
    end else if (sync_i || (state_q == CH_IDLE) || wrap) begin
      state_d = CH_RUN;
      p_d     = '0;
      tick_d  = 1'b1;
      clock_d = 1'b1;
      if (flag_q) begin
        a_d    = pdiv_q;
        flag_d = 1'b0;
      end
    end else begin
      p_d     = p_q + 1'b1;
      clock_d = (32'(p_d) < high);
    end
    if (wr_i) begin
      pdiv_d = wr_div_i;
      flag_d = 1'b1;
    end
  end

  // State and output registers; reset clears outputs asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= CH_IDLE;
      p_q     <= '0;
      a_q     <= RESET_DIV;
      pdiv_q  <= RESET_DIV;
      flag_q  <= 1'b0;
      clock_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      pdiv_q  <= pdiv_d;
      flag_q  <= flag_d;
      clock_q <= clock_d;
      tick_q  <= tick_d;
    end
  end

  assign pending_o = flag_q;
  assign clock_o   = clock_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/baud_clock_bank.sv
// Bank of independent programmable clock/tick dividers sharing one clock.
module baud_clock_bank
  import baud_clock_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 150_000_000,
  parameter int unsigned BAUD_RATE       = 9600,
  parameter int          CHANNELS        = 2,
  parameter int          DIV_WIDTH       = 16
) (
  input  logic              clockIN,
  input  logic              resetnIN,
  baud_clock_bank_if.slave  bus
);

  localparam int unsigned DEFAULT_DIV = calc_default_div(CLOCK_FREQUENCY, BAUD_RATE);

  logic [CHANNELS-1:0] wr_sel;
  logic [CHANNELS-1:0] pending_w;
  logic [CHANNELS-1:0] clock_w;
  logic [CHANNELS-1:0] tick_w;

  // Out-of-range channel numbers match no instance, so such writes vanish.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign wr_sel[gi] = bus.cfgWrIN && (32'(bus.cfgChanIN) == 32'(gi));

    baud_clock_channel #(
      .DIV_WIDTH (DIV_WIDTH),
      .RESET_DIV (DIV_WIDTH'(DEFAULT_DIV))
    ) u_chan (
      .clk_i     (clockIN),
      .rst_n_i   (resetnIN),
      .enable_i  (bus.enableIN[gi]),
      .sync_i    (bus.syncIN),
      .wr_i      (wr_sel[gi]),
      .wr_div_i  (bus.cfgDivIN),
      .pending_o (pending_w[gi]),
      .clock_o   (clock_w[gi]),
      .tick_o    (tick_w[gi])
    );
  end

  assign bus.pendingOUT = pending_w;
  assign bus.clockOUT   = clock_w;
  assign bus.tickOUT    = tick_w;

endmodule

// File: tb/tb_baud_clock_bank.sv
// Randomised and directed bench for baud_clock_bank against a period-position model.
module tb_baud_clock_bank;

  localparam int CH  = 3;
  localparam int DW  = 16;
  localparam int DEF = 15625;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  baud_clock_bank_if #(.CHANNELS(CH), .DIV_WIDTH(DW)) bus ();

  baud_clock_bank #(
    .CLOCK_FREQUENCY (150_000_000),
    .BAUD_RATE       (9600),
    .CHANNELS        (CH),
    .DIV_WIDTH       (DW)
  ) dut (
    .clockIN  (clk),
    .resetnIN (rst_n),
    .bus      (bus)
  );

  int vec_count       = 0;
  int miscompare_count = 0;

  // Model: per channel, whether running, cycles into the current period,
  // active/pending divisor values and the pending flag.
  bit m_run  [CH];
  int m_k    [CH];
  int m_act  [CH];
  int m_pend [CH];
  bit m_flag [CH];

  task automatic check_eq(input string tag, input int got, input int exp);
    vec_count++;
    if (got !== exp) begin
      miscompare_count++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_k[c] = 0; m_act[c] = DEF; m_pend[c] = DEF; m_flag[c] = 0;
    end
  endtask

  task automatic model_apply(input int c);
    if (m_flag[c]) begin
      m_act[c]  = m_pend[c];
      m_flag[c] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      if (!bus.enableIN[c]) begin
        m_run[c] = 0;
        m_k[c]   = 0;
        model_apply(c);
      end else if (bus.syncIN || !m_run[c]) begin
        model_apply(c);
        m_run[c] = 1;
        m_k[c]   = 0;
      end else if (m_k[c] + 1 >= eff(m_act[c])) begin
        m_k[c] = 0;
        model_apply(c);
      end else begin
        m_k[c]++;
      end
      if (bus.cfgWrIN && (int'(bus.cfgChanIN) == c)) begin
        m_pend[c] = int'(bus.cfgDivIN);
        m_flag[c] = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int et, ec, ep, d;
    et = 0; ec = 0; ep = 0;
    for (int c = 0; c < CH; c++) begin
      d = eff(m_act[c]);
      if (m_run[c] && m_k[c] == 0) et |= (1 << c);
      if (m_run[c] && m_k[c] < (d - d / 2)) ec |= (1 << c);
      if (m_flag[c]) ep |= (1 << c);
    end
    check_eq({tag, "_tick"},    int'(bus.tickOUT),    et);
    check_eq({tag, "_clock"},   int'(bus.clockOUT),   ec);
    check_eq({tag, "_pending"}, int'(bus.pendingOUT), ep);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input int en, input bit sy, input bit wr, input int chan, input int div);
    bus.enableIN  = CH'(en);
    bus.syncIN    = sy;
    bus.cfgWrIN   = wr;
    bus.cfgChanIN = 2'(chan);
    bus.cfgDivIN  = DW'(div);
  endtask

  initial begin
    int cyc, hi, gap;
    bit started, measured;

    drive(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_outputs("reset");
    rst_n = 1'b1;

    // Default divisor on ch0: period and high/low split.
    drive(1, 0, 0, 0, 0);
    started = 0; measured = 0; cyc = 0; hi = 0;
    for (int i = 0; i < 2 * DEF + 5; i++) begin
      step("default");
      if (i == 0) check_eq("first_tick", int'(bus.tickOUT[0]), 1);
      if (bus.tickOUT[0]) begin
        if (started && !measured) begin
          check_eq("def_period", cyc, DEF);
          check_eq("def_high", hi, (DEF + 1) / 2);
          measured = 1;
        end
        started = 1; cyc = 0; hi = 0;
      end
      cyc++;
      if (bus.clockOUT[0]) hi++;
    end

    // ch1 at 10, then retarget to 4 while running.
    drive(1, 0, 1, 1, 10); step("w10");
    drive(3, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) step("run10");
    drive(3, 0, 1, 1, 4); step("w4");
    drive(3, 0, 0, 0, 0);
    for (int i = 0; i < 25; i++) step("run4");

    // Two writes before the boundary: last value wins.
    drive(3, 0, 1, 1, 5); step("w5");
    drive(3, 0, 1, 1, 6); step("w6");
    drive(3, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("run6");
    drive(3, 0, 1, 1, 5); step("w5b");
    drive(3, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("run5");

    // Divisors 0 and 1 clamp to 2.
    drive(2, 0, 1, 0, 0); step("w0");
    drive(2, 0, 1, 2, 1); step("w1");
    drive(2, 0, 0, 0, 0); step("idle");
    drive(7, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step("run2");

    // Sync two channels at 6 and 9; write on the sync edge stays pending.
    drive(4, 0, 1, 0, 6); step("w6s");
    drive(4, 0, 1, 1, 9); step("w9s");
    drive(7, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("pre_sync");
    drive(3, 1, 1, 0, 6); step("sync");
    check_eq("sync_tick", int'(bus.tickOUT[1:0]), 3);
    check_eq("sync_write_pending", int'(bus.pendingOUT[0]), 1);
    drive(3, 0, 0, 0, 0);
    gap = 0; measured = 0;
    for (int i = 0; i < 40; i++) begin
      step("coinc");
      gap++;
      if (bus.tickOUT[0] && bus.tickOUT[1] && !measured) begin
        check_eq("coinc_gap", gap, 18);
        measured = 1;
      end
    end

    // Out-of-range channel write is ignored.
    drive(3, 0, 1, 3, 2); step("w_oob");
    drive(3, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("oob");

    // Randomised traffic.
    begin
      int en;
      en = 7;
      for (int i = 0; i < 3000; i++) begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range(0, 49) == 0) en ^= (1 << c);
        drive(en, ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
        step("rand");
      end
    end

    // Asynchronous reset mid-period.
    drive(7, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule
